sonar_scan_scheduler: RTL and testbench

Round-robin ranging controller for up to NUM_SENSORS MaxSonar units that share one distance-processing datapath. It fires one sensor at a time through its RX trigger line, steers the shared datapath to that sensor and captures the first fresh 8-bit distance. It then waits a settle gap and moves to the next sensor, which prevents acoustic crosstalk. Captured results go into a per-sensor distance bank read by the bus-facing register logic.

---
 rtl/sonar_scan_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_sonar_scan_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sonar_scan_scheduler.sv
// sonar_scan_scheduler
// Round-robin ranging sequencer for MaxSonar units that share one distance
// datapath. Each slot fires one sensor, waits for the first fresh distance (or
// a timeout), then idles for a settle gap so echoes from one unit cannot be
// mistaken for the next unit's reading.
module sonar_scan_scheduler #(
    parameter int NUM_SENSORS    = 4,
    parameter int TRIG_CYCLES    = 2500,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int GAP_CYCLES     = 5000000
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   enable,
    output logic [NUM_SENSORS-1:0]                                 sensor_rx,
    output logic [((NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1)-1:0] sel,
    input  logic [7:0]                                             distance,
    input  logic                                                   new_dist,
    output logic [8*NUM_SENSORS-1:0]                               dist_bank,
    output logic [NUM_SENSORS-1:0]                                 dist_valid,
    output logic [NUM_SENSORS-1:0]                                 timeout_flag,
    output logic                                                   busy,
    output logic                                                   scan_done
);

    localparam int SEL_W   = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int MAX_A   = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_CNT = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_ZERO  = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(NUM_SENSORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIGGER = 3'd1,
        ST_WAIT    = 3'd2,
        ST_GAP     = 3'd3,
        ST_ADVANCE = 3'd4
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [CNT_W-1:0]         cnt_r, cnt_nxt_s;
    logic [SEL_W-1:0]         sel_r, sel_nxt_s;
    logic                     new_dist_prev_r;
    logic                     edge_s;
    logic                     capture_s;
    logic                     expire_s;
    logic [NUM_SENSORS-1:0]   rx_onehot_s;
    logic [NUM_SENSORS-1:0]   sensor_rx_r;
    logic [8*NUM_SENSORS-1:0] dist_bank_r;
    logic [NUM_SENSORS-1:0]   dist_valid_r;
    logic [NUM_SENSORS-1:0]   timeout_flag_r;
    logic                     busy_r;
    logic                     scan_done_r;

    // A fresh sample is a rising edge of the level strobe; the history bit
    // resets high so a strobe already asserted at reset release is not an edge.
    assign edge_s = new_dist & ~new_dist_prev_r;

    // Next-state, shared counter and sensor-index sequencing.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        sel_nxt_s   = sel_r;
        capture_s   = 1'b0;
        expire_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s = CNT_ZERO;
                if (enable) begin
                    state_nxt_s = ST_TRIGGER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_TRIGGER: begin
                if (cnt_r == TRIG_LAST) begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_TRIGGER;
                end
            end
            ST_WAIT: begin
                // A sample arriving on the last timeout cycle still counts.
                if (edge_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == TO_LAST) begin
                    expire_s    = 1'b1;
                    state_nxt_s = ST_GAP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_ADVANCE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_GAP;
                end
            end
            ST_ADVANCE: begin
                cnt_nxt_s = CNT_ZERO;
                if (sel_r == SEL_LAST) begin
                    sel_nxt_s = SEL_ZERO;
                end else begin
                    sel_nxt_s = sel_r + SEL_ONE;
                end
                if (enable) begin
                    state_nxt_s = ST_TRIGGER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // One-hot trigger pattern for the sensor that will own the next cycle.
    always_comb begin
        rx_onehot_s = {NUM_SENSORS{1'b0}};
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (SEL_W'(i) == sel_nxt_s) begin
                rx_onehot_s[i] = 1'b1;
            end else begin
                rx_onehot_s[i] = 1'b0;
            end
        end
    end

    // Sequencer state and registered outputs, decoded from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            sel_r           <= SEL_ZERO;
            new_dist_prev_r <= 1'b1;
            sensor_rx_r     <= {NUM_SENSORS{1'b0}};
            busy_r          <= 1'b0;
            scan_done_r     <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            sel_r           <= sel_nxt_s;
            new_dist_prev_r <= new_dist;
            sensor_rx_r     <= (state_nxt_s == ST_TRIGGER) ? rx_onehot_s : {NUM_SENSORS{1'b0}};
            busy_r          <= (state_nxt_s != ST_IDLE);
            scan_done_r     <= (state_nxt_s == ST_ADVANCE) && (sel_r == SEL_LAST);
        end
    end

    // Per-sensor result bank: capture updates distance and validity, expiry
    // only raises the timeout flag and keeps the previous distance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dist_bank_r    <= {(8*NUM_SENSORS){1'b0}};
            dist_valid_r   <= {NUM_SENSORS{1'b0}};
            timeout_flag_r <= {NUM_SENSORS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (SEL_W'(i) == sel_r) begin
                    if (capture_s) begin
                        dist_bank_r[8*i +: 8] <= distance;
                        dist_valid_r[i]       <= 1'b1;
                        timeout_flag_r[i]     <= 1'b0;
                    end else if (expire_s) begin
                        timeout_flag_r[i]     <= 1'b1;
                    end
                end
            end
        end
    end

    assign sensor_rx    = sensor_rx_r;
    assign sel          = sel_r;
    assign dist_bank    = dist_bank_r;
    assign dist_valid   = dist_valid_r;
    assign timeout_flag = timeout_flag_r;
    assign busy         = busy_r;
    assign scan_done    = scan_done_r;

endmodule

// File: tb/tb_sonar_scan_scheduler.sv
// tb_sonar_scan_scheduler
// Slot-level reference model: each slot is described by when the strobe rises
// in WAIT (if at all), and expected outputs follow from slot-length arithmetic.
module tb_sonar_scan_scheduler;

    localparam int N    = 4;
    localparam int TRIG = 4;
    localparam int TMO  = 50;
    localparam int GAP  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           enable;
    logic [N-1:0]   sensor_rx;
    logic [1:0]     sel;
    logic [7:0]     distance;
    logic           new_dist;
    logic [8*N-1:0] dist_bank;
    logic [N-1:0]   dist_valid;
    logic [N-1:0]   timeout_flag;
    logic           busy;
    logic           scan_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_bank[N];
    logic       m_valid[N];
    logic       m_to[N];
    int         m_sel;

    sonar_scan_scheduler #(
        .NUM_SENSORS(N), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .sensor_rx(sensor_rx), .sel(sel),
        .distance(distance), .new_dist(new_dist), .dist_bank(dist_bank),
        .dist_valid(dist_valid), .timeout_flag(timeout_flag), .busy(busy),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8*N-1:0] m_bank_vec();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = m_bank[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_valid_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_valid[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_to_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_to[i];
        return v;
    endfunction

    function automatic logic [N-1:0] m_rx(input int s);
        logic [N-1:0] v;
        v = {{(N-1){1'b0}}, 1'b1};
        return v << s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_bank[i]  = 8'h00;
            m_valid[i] = 1'b0;
            m_to[i]    = 1'b0;
        end
        m_sel = 0;
    endtask

    // Entered while observing TRIGGER cycle 0. hold: strobe high from TRIGGER
    // until WAIT cycle hold-1. edge_at: WAIT cycle the strobe rises (<0 = never).
    task automatic run_slot(input int hold, input int edge_at, input logic [7:0] d, input logic en_keep);
        bit hit;
        int wait_len;
        hit      = (edge_at >= 0) && (edge_at < TMO);
        wait_len = hit ? edge_at + 1 : TMO;
        new_dist = (hold > 0);
        for (int c = 0; c < TRIG; c++) begin
            n_cmp++;
            if (sensor_rx !== m_rx(m_sel)) begin
                n_err++; $display("FAIL trig_rx c=%0d: got %b expected %b", c, sensor_rx, m_rx(m_sel));
            end
            n_cmp++;
            if (sel !== 2'(m_sel)) begin
                n_err++; $display("FAIL trig_sel: got %0d expected %0d", sel, m_sel);
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL trig_busy: got %b expected 1", busy);
            end
            tick();
        end
        enable = en_keep;
        for (int k = 0; k < wait_len; k++) begin
            n_cmp++;
            if (sensor_rx !== {N{1'b0}}) begin
                n_err++; $display("FAIL wait_rx k=%0d: got %b expected 0", k, sensor_rx);
            end
            n_cmp++;
            if (scan_done !== 1'b0) begin
                n_err++; $display("FAIL wait_scan_done k=%0d: got %b expected 0", k, scan_done);
            end
            new_dist = (k < hold) || (hit && (k >= edge_at));
            distance = (hit && (k == edge_at)) ? d : 8'($urandom);
            tick();
        end
        if (hit) begin
            m_bank[m_sel]  = d;
            m_valid[m_sel] = 1'b1;
            m_to[m_sel]    = 1'b0;
        end else begin
            m_to[m_sel]    = 1'b1;
        end
        n_cmp++;
        if (dist_bank !== m_bank_vec()) begin
            n_err++; $display("FAIL bank: got %h expected %h", dist_bank, m_bank_vec());
        end
        n_cmp++;
        if (dist_valid !== m_valid_vec()) begin
            n_err++; $display("FAIL valid: got %b expected %b", dist_valid, m_valid_vec());
        end
        n_cmp++;
        if (timeout_flag !== m_to_vec()) begin
            n_err++; $display("FAIL timeout_flag: got %b expected %b", timeout_flag, m_to_vec());
        end
        for (int g = 0; g < GAP; g++) begin
            n_cmp++;
            if ((sensor_rx !== {N{1'b0}}) || (busy !== 1'b1) || (scan_done !== 1'b0)) begin
                n_err++; $display("FAIL gap g=%0d: got rx=%b busy=%b done=%b expected rx=0 busy=1 done=0",
                                  g, sensor_rx, busy, scan_done);
            end
            new_dist = 1'($urandom);
            distance = 8'($urandom);
            tick();
        end
        n_cmp++;
        if (scan_done !== (m_sel == N-1)) begin
            n_err++; $display("FAIL adv_scan_done sel=%0d: got %b expected %b", m_sel, scan_done, (m_sel == N-1));
        end
        n_cmp++;
        if ((busy !== 1'b1) || (sel !== 2'(m_sel))) begin
            n_err++; $display("FAIL adv_state: got busy=%b sel=%0d expected busy=1 sel=%0d", busy, sel, m_sel);
        end
        new_dist = 1'b0;
        tick();
        m_sel = (m_sel == N-1) ? 0 : m_sel + 1;
        n_cmp++;
        if (sel !== 2'(m_sel)) begin
            n_err++; $display("FAIL next_sel: got %0d expected %0d", sel, m_sel);
        end
        if (!en_keep) begin
            n_cmp++;
            if ((busy !== 1'b0) || (sensor_rx !== {N{1'b0}})) begin
                n_err++; $display("FAIL stop_idle: got busy=%b rx=%b expected busy=0 rx=0", busy, sensor_rx);
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        enable   = 1'b0;
        new_dist = 1'b1;
        distance = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        n_cmp++;
        if ((sensor_rx !== 4'b0000) || (sel !== 2'd0) || (busy !== 1'b0) || (scan_done !== 1'b0)) begin
            n_err++; $display("FAIL reset_ctl: got rx=%b sel=%0d busy=%b done=%b expected all 0",
                              sensor_rx, sel, busy, scan_done);
        end
        n_cmp++;
        if ((dist_bank !== 32'h0) || (dist_valid !== 4'b0) || (timeout_flag !== 4'b0)) begin
            n_err++; $display("FAIL reset_bank: got bank=%h valid=%b to=%b expected all 0",
                              dist_bank, dist_valid, timeout_flag);
        end
        repeat (3) tick();
        n_cmp++;
        if ((busy !== 1'b0) || (sensor_rx !== 4'b0000)) begin
            n_err++; $display("FAIL idle_hold: got busy=%b rx=%b expected busy=0 rx=0", busy, sensor_rx);
        end
    endtask

    task automatic test_first_scan();
        enable = 1'b1;
        tick();
        run_slot(0, 5, 8'h88, 1'b1);
        run_slot(0, -1, 8'h00, 1'b1);
        run_slot(0, int'($urandom_range(0, 40)), 8'hCA, 1'b1);
        run_slot(0, TMO - 1, 8'h75, 1'b1);
    endtask

    task automatic test_hold_high();
        run_slot(10, 20, 8'h93, 1'b1);
    endtask

    task automatic test_random();
        int h;
        int e;
        for (int r = 0; r < 8; r++) begin
            h = int'($urandom_range(0, 3));
            e = int'($urandom_range(h + 1, 59));
            if (e >= TMO) e = -1;
            run_slot(h, e, 8'($urandom), 1'b1);
        end
    endtask

    task automatic test_enable_drop();
        for (int r = 0; r < N && m_sel != 2; r++) begin
            run_slot(0, int'($urandom_range(0, 60)), 8'($urandom), 1'b1);
        end
        run_slot(0, int'($urandom_range(0, 49)), 8'($urandom), 1'b0);
        for (int r = 0; r < 4; r++) begin
            tick();
            n_cmp++;
            if ((busy !== 1'b0) || (sensor_rx !== 4'b0000) || (sel !== 2'd3)) begin
                n_err++; $display("FAIL stay_idle: got busy=%b rx=%b sel=%0d expected busy=0 rx=0 sel=3",
                                  busy, sensor_rx, sel);
            end
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        tick();
        n_cmp++;
        if (sensor_rx !== 4'b1000) begin
            n_err++; $display("FAIL pre_reset_rx: got %b expected 1000", sensor_rx);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        n_cmp++;
        if ((sensor_rx !== 4'b0000) || (busy !== 1'b0) || (sel !== 2'd0)) begin
            n_err++; $display("FAIL async_reset: got rx=%b busy=%b sel=%0d expected rx=0 busy=0 sel=0",
                              sensor_rx, busy, sel);
        end
        n_cmp++;
        if ((dist_bank !== m_bank_vec()) || (dist_valid !== 4'b0) || (timeout_flag !== 4'b0)) begin
            n_err++; $display("FAIL async_reset_bank: got bank=%h valid=%b to=%b expected all 0",
                              dist_bank, dist_valid, timeout_flag);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        run_slot(0, int'($urandom_range(0, 49)), 8'($urandom), 1'b1);
        run_slot(0, -1, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_scan();
        test_hold_high();
        test_random();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
